// File: rtl/isp_ctrl_pkg.sv
// Shared definitions for the ISP pipeline control block:
// register offsets, CMD/STATUS bit positions, FSM encoding.
package isp_ctrl_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CMD    = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_TARGET = 3'd3;
  localparam logic [2:0] OFF_COUNT  = 3'd4;
  localparam logic [2:0] OFF_IRQEN  = 3'd5;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ABORTD = 2;

  localparam int IRQ_DONE   = 0;
  localparam int IRQ_ABORTD = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic        en;
    logic [2:0]  off;
    logic [31:0] data;
  } reg_wr_t;

endpackage

// File: rtl/ahb_reg_if.sv
// AHB-Lite address-phase capture and data-phase write strobe
// for small word-addressed register banks.
module ahb_reg_if
  import isp_ctrl_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        rd_vld,
  output logic [2:0]  rd_off,
  output reg_wr_t     wr
);

  logic       ph_vld;
  logic       ph_wr;
  logic [2:0] ph_off;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_vld <= 1'b0;
      ph_wr  <= 1'b0;
      ph_off <= '0;
    end else if (HREADY) begin
      ph_vld <= HSEL & HTRANS[1];
      ph_wr  <= HWRITE;
      ph_off <= HADDR[4:2];
    end
  end

  assign rd_vld  = ph_vld & ~ph_wr;
  assign rd_off  = ph_off;
  assign wr.en   = ph_vld & ph_wr;
  assign wr.off  = ph_off;
  assign wr.data = HWDATA;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

endmodule

// File: rtl/ahblite_isp_ctrl.sv
// AHB-Lite control/status block for an ISP pipeline:
// channel enables, frame counting run FSM, interrupts.
module ahblite_isp_ctrl
  import isp_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [NUM_CH-1:0] ch_en,
  output logic              run,
  input  logic              frame_done,
  input  logic              core_idle,
  output logic              irq
);

  logic       rd_vld;
  logic [2:0] rd_off;
  reg_wr_t    wr;

  ahb_reg_if u_if (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HWDATA  (HWDATA),
    .HREADY  (HREADY),
    .rd_vld  (rd_vld),
    .rd_off  (rd_off),
    .wr      (wr)
  );

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  state_t            state, state_n;
  logic [NUM_CH-1:0] ctrl;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  count;
  logic [1:0]        irqen;
  logic              done;
  logic              abortd;
  logic              busy;

  logic wr_ctrl, wr_cmd, wr_stat, wr_tgt, wr_irqen;

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_cmd   = 1'b0;
    wr_stat  = 1'b0;
    wr_tgt   = 1'b0;
    wr_irqen = 1'b0;
    if (wr.en) begin
      unique case (1'b1)
        wr.off == OFF_CTRL:   wr_ctrl  = 1'b1;
        wr.off == OFF_CMD:    wr_cmd   = 1'b1;
        wr.off == OFF_STATUS: wr_stat  = 1'b1;
        wr.off == OFF_TARGET: wr_tgt   = 1'b1;
        wr.off == OFF_IRQEN:  wr_irqen = 1'b1;
        default: ;
      endcase
    end
  end

  // Abort outranks start when both bits are written together
  logic abort_w, start_w;
  assign abort_w = wr_cmd & wr.data[CMD_ABORT];
  assign start_w = wr_cmd & wr.data[CMD_START] & ~abort_w;

  logic [CNT_W-1:0] cnt_inc;
  logic             tgt_hit;
  logic             go;
  logic             counting;
  logic             done_set;
  logic             abortd_set;

  assign cnt_inc  = (&count) ? count : count + CNT_W'(1);
  assign tgt_hit  = (|target) && (cnt_inc == target);
  assign go       = (state == S_IDLE) & start_w & (|ctrl);
  assign counting = (state == S_RUN) | (state == S_DRAIN);
  assign done_set = (state == S_RUN) & frame_done & ~abort_w & tgt_hit;
  assign abortd_set = (state == S_DRAIN) & core_idle;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    run     = 1'b0;
    busy    = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_n = S_RUN;
      end
      S_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        if (abort_w)                   state_n = S_DRAIN;
        else if (frame_done & tgt_hit) state_n = S_IDLE;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (core_idle) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl   <= '0;
      target <= '0;
      irqen  <= '0;
      count  <= '0;
      done   <= 1'b0;
      abortd <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl   <= wr.data[NUM_CH-1:0];
      if (wr_tgt)   target <= wr.data[CNT_W-1:0];
      if (wr_irqen) irqen  <= wr.data[1:0];
      if (go)                           count <= '0;
      else if (counting & frame_done)   count <= cnt_inc;
      // Set events win over a coincident W1C
      if (done_set)
        done <= 1'b1;
      else if (go | (wr_stat & wr.data[ST_DONE]))
        done <= 1'b0;
      if (abortd_set)
        abortd <= 1'b1;
      else if (wr_stat & wr.data[ST_ABORTD])
        abortd <= 1'b0;
    end
  end

  assign ch_en = ctrl;
  assign irq   = (done & irqen[IRQ_DONE]) | (abortd & irqen[IRQ_ABORTD]);

  always_comb begin
    HRDATA = '0;
    if (rd_vld) begin
      case (rd_off)
        OFF_CTRL:   HRDATA = 32'(ctrl);
        OFF_STATUS: begin
          HRDATA[ST_BUSY]   = busy;
          HRDATA[ST_DONE]   = done;
          HRDATA[ST_ABORTD] = abortd;
        end
        OFF_TARGET: HRDATA = 32'(target);
        OFF_COUNT:  HRDATA = 32'(count);
        OFF_IRQEN:  HRDATA = 32'(irqen);
        default:    HRDATA = '0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HPROT, wr.data};

endmodule

// File: tb/tb_ahblite_isp_ctrl.sv
// Directed, table-driven bench for ahblite_isp_ctrl with
// hand-written sequences for coincident-edge and reset cases.
module tb_ahblite_isp_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [3:0]  ch_en;
  logic        run;
  logic        frame_done;
  logic        core_idle;
  logic        irq;

  ahblite_isp_ctrl #(.NUM_CH(4), .CNT_W(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HPROT      (HPROT),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .ch_en      (ch_en),
    .run        (run),
    .frame_done (frame_done),
    .core_idle  (core_idle),
    .irq        (irq)
  );

  always #5 HCLK = ~HCLK;

  typedef enum { K_WR, K_RD, K_FD, K_CI, K_PIN, K_WAIT } kind_t;

  typedef struct {
    kind_t       kind;
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [2:0] A_CTRL = 3'd0, A_CMD = 3'd1, A_STAT = 3'd2;
  localparam logic [2:0] A_TGT = 3'd3, A_CNT = 3'd4, A_IEN = 3'd5;

  function automatic void add(kind_t k, logic [2:0] o,
                              logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.kind = k; v.off = o; v.data = d; v.exp = e;
    vq.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return {26'd0, irq, run, ch_en};
  endfunction

  task automatic bus_wr(logic [2:0] o, logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {27'd0, o, 2'b00};
    @(posedge HCLK); #1;
    HWDATA = d; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_rd(logic [2:0] o, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
    HADDR = {27'd0, o, 2'b00};
    @(posedge HCLK); #1;
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic pulse(int n);
    for (int j = 0; j < n; j++) begin
      frame_done = 1'b1;
      @(posedge HCLK); #1;
    end
    frame_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HSIZE = 3'b010; HPROT = 4'b0011; HWRITE = 1'b0;
    HWDATA = '0; HREADY = 1'b1; frame_done = 1'b0; core_idle = 1'b1;

    // reset state
    add(K_PIN, 0, 0, 32'h00);
    add(K_RD, A_STAT, 0, 32'h0);
    add(K_RD, A_CTRL, 0, 32'h0);
    // basic 3-frame run, CTRL=5
    add(K_WR, A_CTRL, 32'h5, 0);
    add(K_WR, A_TGT, 32'h3, 0);
    add(K_WR, A_CMD, 32'h1, 0);
    add(K_PIN, 0, 0, 32'h15);
    add(K_RD, A_STAT, 0, 32'h1);
    add(K_FD, 0, 2, 0);
    add(K_PIN, 0, 0, 32'h15);
    add(K_RD, A_CNT, 0, 32'h2);
    add(K_FD, 0, 1, 0);
    add(K_PIN, 0, 0, 32'h05);
    add(K_RD, A_CNT, 0, 32'h3);
    add(K_RD, A_STAT, 0, 32'h2);
    // done interrupt and W1C
    add(K_WR, A_IEN, 32'h1, 0);
    add(K_PIN, 0, 0, 32'h25);
    add(K_WR, A_STAT, 32'h2, 0);
    add(K_PIN, 0, 0, 32'h05);
    add(K_RD, A_STAT, 0, 32'h0);
    // start with CTRL=0 and abort in IDLE are ignored
    add(K_WR, A_CTRL, 32'h0, 0);
    add(K_WR, A_CMD, 32'h1, 0);
    add(K_PIN, 0, 0, 32'h00);
    add(K_RD, A_STAT, 0, 32'h0);
    add(K_WR, A_CMD, 32'h2, 0);
    add(K_RD, A_STAT, 0, 32'h0);
    // reserved offsets
    add(K_WR, 3'd6, 32'hFFFF_FFFF, 0);
    add(K_RD, 3'd6, 0, 32'h0);
    add(K_RD, 3'd7, 0, 32'h0);
    // continuous mode, abort through DRAIN
    add(K_WR, A_CTRL, 32'hF, 0);
    add(K_RD, A_CTRL, 0, 32'hF);
    add(K_WR, A_TGT, 32'h0, 0);
    add(K_CI, 0, 0, 0);
    add(K_WR, A_CMD, 32'h1, 0);
    add(K_FD, 0, 10, 0);
    add(K_RD, A_CNT, 0, 32'hA);
    add(K_RD, A_STAT, 0, 32'h1);
    add(K_PIN, 0, 0, 32'h1F);
    add(K_WR, A_CMD, 32'h2, 0);
    add(K_PIN, 0, 0, 32'h0F);
    add(K_WAIT, 0, 4, 0);
    add(K_RD, A_STAT, 0, 32'h1);
    add(K_FD, 0, 1, 0);
    add(K_RD, A_CNT, 0, 32'hB);
    add(K_RD, A_STAT, 0, 32'h1);
    add(K_CI, 0, 1, 0);
    add(K_RD, A_STAT, 0, 32'h4);
    add(K_WR, A_IEN, 32'h2, 0);
    add(K_PIN, 0, 0, 32'h2F);
    add(K_WR, A_STAT, 32'h4, 0);
    add(K_PIN, 0, 0, 32'h0F);
    add(K_RD, A_STAT, 0, 32'h0);
    // start+abort together goes to DRAIN
    add(K_WR, A_TGT, 32'h2, 0);
    add(K_CI, 0, 0, 0);
    add(K_WR, A_CMD, 32'h1, 0);
    add(K_PIN, 0, 0, 32'h1F);
    add(K_WR, A_CMD, 32'h3, 0);
    add(K_PIN, 0, 0, 32'h0F);
    add(K_RD, A_STAT, 0, 32'h1);
    add(K_CI, 0, 1, 0);
    add(K_RD, A_STAT, 0, 32'h4);
    add(K_WR, A_STAT, 32'h4, 0);
    // TARGET lowered below COUNT mid-run keeps running
    add(K_WR, A_TGT, 32'h0, 0);
    add(K_WR, A_CMD, 32'h1, 0);
    add(K_FD, 0, 3, 0);
    add(K_WR, A_TGT, 32'h2, 0);
    add(K_FD, 0, 1, 0);
    add(K_PIN, 0, 0, 32'h1F);
    add(K_RD, A_CNT, 0, 32'h4);
    add(K_WR, A_CMD, 32'h2, 0);
    add(K_RD, A_STAT, 0, 32'h4);
    add(K_PIN, 0, 0, 32'h2F);
    add(K_WR, A_STAT, 32'h4, 0);
    add(K_PIN, 0, 0, 32'h0F);

    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    foreach (vq[i]) begin
      vec_t v;
      string nm;
      v = vq[i];
      nm = $sformatf("vec%0d", i);
      case (v.kind)
        K_WR:   bus_wr(v.off, v.data);
        K_RD: begin
          bus_rd(v.off, rd);
          chk({nm, "_rd"}, rd, v.exp);
        end
        K_FD:   pulse(int'(v.data));
        K_CI: begin
          core_idle = v.data[0];
          @(posedge HCLK); #1;
        end
        K_PIN:  chk({nm, "_pins"}, pins(), v.exp);
        K_WAIT: repeat (int'(v.data)) begin @(posedge HCLK); #1; end
        default: ;
      endcase
    end

    // W1C of done landing on the completion edge
    bus_wr(A_TGT, 32'h1);
    bus_wr(A_IEN, 32'h1);
    bus_wr(A_CMD, 32'h1);
    chk("coin_run", pins(), 32'h1F);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {27'd0, A_STAT, 2'b00};
    @(posedge HCLK); #1;
    HWDATA = 32'h2; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    frame_done = 1'b1;
    @(posedge HCLK); #1;
    frame_done = 1'b0;
    chk("coin_pins", pins(), 32'h2F);
    bus_rd(A_STAT, rd);
    chk("coin_done", rd, 32'h2);

    // async reset mid-RUN
    bus_wr(A_TGT, 32'h0);
    bus_wr(A_CMD, 32'h1);
    pulse(2);
    bus_rd(A_CNT, rd);
    chk("pre_rst_cnt", rd, 32'h2);
    #3 HRESETn = 1'b0;
    #1;
    chk("rst_pins", pins(), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    bus_rd(A_CNT, rd);
    chk("rst_cnt", rd, 32'h0);
    bus_rd(A_STAT, rd);
    chk("rst_stat", rd, 32'h0);
    chk("hreadyout", {30'd0, HRESP, HREADYOUT}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_isp_ctrl.md
AHBLITE_ISP_CTRL -- requirements
Module: ahblite_isp_ctrl

Interface
REQ-001 Parameter: NUM_CH, default 4, number of pipeline channel enables (1..8).
REQ-002 Parameter: CNT_W, default 16, width of frame target and frame counter (1..32).
REQ-003 Port: HCLK  input  1  bus and core clock.
REQ-004 Port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 Ports: HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  input  AHB-Lite slave inputs.
REQ-006 Ports: HREADYOUT  output  1, tied 1; HRESP  output  1, tied 0; HRDATA  output  32  read data.
REQ-007 Port: ch_en  output  NUM_CH  per-channel enable to the processing core.
REQ-008 Port: run  output  1  core run request, high only in state RUN.
REQ-009 Port: frame_done  input  1  single-cycle pulse from core at end of each frame.
REQ-010 Port: core_idle  input  1  core has no frame in flight.
REQ-011 Port: irq  output  1  level interrupt.

Function
REQ-012 The address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY; HADDR[4:2] and HWRITE are registered, and the write is applied in the following cycle from HWDATA.
REQ-013 Register map (HADDR[4:2]) SHALL be: 0 CTRL rw [NUM_CH-1:0] channel enables; 1 CMD wo bit0 start, bit1 abort; 2 STATUS bit0 busy ro, bit1 done w1c, bit2 abort_done w1c; 3 TARGET rw [CNT_W-1:0]; 4 COUNT ro [CNT_W-1:0]; 5 IRQEN rw bits[1:0]; 6-7 reserved, read 0, writes ignored.
REQ-014 HRDATA SHALL be combinational from the registered address-phase offset, with unused bits 0; CMD reads 0.
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN on a start write when CTRL has any bit set; COUNT clears to 0 and done clears on the same edge; a start with CTRL==0 is ignored.
REQ-017 In RUN each frame_done SHALL increment COUNT; COUNT saturates at all-ones.
REQ-018 RUN->IDLE when TARGET!=0 and the incremented COUNT equals TARGET; done sets on that edge.
REQ-019 TARGET==0 SHALL mean continuous mode: RUN persists until abort.
REQ-020 Abort write in RUN SHALL go to DRAIN; DRAIN->IDLE when core_idle is high; abort_done sets on that edge.
REQ-021 frame_done in DRAIN SHALL still increment COUNT but SHALL NOT set done.
REQ-022 Start in RUN or DRAIN SHALL be ignored; abort in IDLE SHALL be ignored; start and abort set together SHALL be treated as abort.
REQ-023 CTRL writes SHALL take effect immediately in every state; ch_en = CTRL.
REQ-024 TARGET written during RUN SHALL be used from the next frame_done; if COUNT already exceeds the new TARGET, run continues until abort.
REQ-025 busy SHALL be 1 in RUN and DRAIN.
REQ-026 irq SHALL equal (done & IRQEN[0]) | (abort_done & IRQEN[1]); clearing via W1C drops irq the cycle after the write data phase.
REQ-027 A W1C clear coinciding with a set event SHALL leave the bit set.

Reset
REQ-028 On HRESETn low all registers SHALL clear asynchronously: state IDLE, CTRL 0, TARGET 0, COUNT 0, IRQEN 0, done 0, abort_done 0, registered address phase invalid.
REQ-029 Reset outputs SHALL be ch_en 0, run 0, irq 0, HRDATA 0; reset mid-RUN drops run without a DRAIN phase.

Structure
REQ-030 Register offsets, STATUS/CMD bit positions and the FSM state encoding SHALL live in a shared package isp_ctrl_pkg.
REQ-031 The AHB address-phase capture and write decode SHALL be one sub-module, ahb_reg_if, reusable by other pipeline control blocks; FSM and counters stay in the top.

Verification
REQ-032 Write CTRL=0x5, TARGET=3, start; three frame_done pulses -> run high until the third, COUNT=3, done=1, run low the cycle after.
REQ-033 IRQEN=1, complete a run -> irq=1; write STATUS=0x2 -> irq=0, done=0.
REQ-034 TARGET=0, start, 10 frame_done -> COUNT=10, still RUN; abort with core_idle=0 for 4 cycles -> busy=1 in DRAIN; core_idle=1 -> IDLE, abort_done=1.
REQ-035 CTRL=0, start -> state stays IDLE, run=0, busy=0.
REQ-036 Start+abort in one CMD write while RUN -> DRAIN; W1C of done coinciding with completion edge -> done remains 1.
REQ-037 Assert HRESETn mid-RUN with COUNT=2 -> run, ch_en, irq, COUNT all 0 immediately; reads of offsets 6/7 -> 0x00000000.
